// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display with double-buffered
// content, frame-boundary commit handshake and per-slot PWM brightness.
module seg_scan_ctrl #(
    parameter int unsigned DWELL = 100_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] val_i,
    input  logic [3:0]  blank_i,
    input  logic [3:0]  dp_i,
    input  logic [2:0]  bright_i,
    input  logic        load_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic        frame_o,
    output logic [11:0] seg_o
);

    localparam int unsigned SLOT_LEN = DWELL / 8;
    localparam int unsigned CW       = $clog2(DWELL);
    localparam int unsigned SW       = $clog2(SLOT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(SLOT_LEN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } hs_state_t;

    hs_state_t state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [2:0]    slot_q, slot_d;
    logic [1:0]    digit_q, digit_d;
    logic [2:0]    bright_q, bright_d;

    logic [15:0] pend_val_q, shad_val_q;
    logic [3:0]  pend_blank_q, shad_blank_q;
    logic [3:0]  pend_dp_q, shad_dp_q;

    logic        ack_q, frame_q;
    logic [11:0] seg_q, seg_d;

    logic dwell_end, sub_end, frame_edge;
    logic capture, commit;
    logic [3:0] nib;
    logic       lit;

    assign dwell_end  = (cnt_q == CNT_LAST);
    assign sub_end    = (sub_q == SUB_LAST);
    assign frame_edge = dwell_end && (digit_q == 2'd3);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] h;
        case (n)
            4'h0: h = 7'h40;
            4'h1: h = 7'h79;
            4'h2: h = 7'h24;
            4'h3: h = 7'h30;
            4'h4: h = 7'h19;
            4'h5: h = 7'h12;
            4'h6: h = 7'h02;
            4'h7: h = 7'h78;
            4'h8: h = 7'h00;
            4'h9: h = 7'h10;
            4'hA: h = 7'h08;
            4'hB: h = 7'h03;
            4'hC: h = 7'h46;
            4'hD: h = 7'h21;
            4'hE: h = 7'h06;
            default: h = 7'h0E;
        endcase
        return h;
    endfunction

    // Scan counters: the slot sub-counter is realigned at every digit change so
    // slot 7 always ends exactly on the dwell boundary.
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        sub_d    = sub_q + 1'b1;
        slot_d   = slot_q;
        digit_d  = digit_q;
        bright_d = bright_q;
        if (dwell_end) begin
            cnt_d    = '0;
            sub_d    = '0;
            slot_d   = '0;
            digit_d  = digit_q + 1'b1;
            bright_d = bright_i;
        end else if (sub_end) begin
            sub_d  = '0;
            slot_d = slot_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    capture = 1'b1;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (frame_edge) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode uses the current scan state; the register adds the one-cycle latency.
    always_comb begin
        nib   = shad_val_q[{digit_q, 2'b00} +: 4];
        lit   = (slot_q <= bright_q) && !shad_blank_q[digit_q];
        seg_d = 12'hFFF;
        if (lit) begin
            seg_d = {~(4'b0001 << digit_q), ~shad_dp_q[digit_q], hex7(nib)};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sub_q        <= '0;
            slot_q       <= '0;
            digit_q      <= '0;
            bright_q     <= 3'd7;
            pend_val_q   <= '0;
            pend_blank_q <= '0;
            pend_dp_q    <= '0;
            shad_val_q   <= '0;
            shad_blank_q <= '0;
            shad_dp_q    <= '0;
            ack_q        <= 1'b0;
            frame_q      <= 1'b0;
            seg_q        <= 12'hFFF;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            slot_q   <= slot_d;
            digit_q  <= digit_d;
            bright_q <= bright_d;
            if (capture) begin
                pend_val_q   <= val_i;
                pend_blank_q <= blank_i;
                pend_dp_q    <= dp_i;
            end
            if (commit) begin
                shad_val_q   <= pend_val_q;
                shad_blank_q <= pend_blank_q;
                shad_dp_q    <= pend_dp_q;
            end
            ack_q   <= commit;
            frame_q <= frame_edge;
            seg_q   <= seg_d;
        end
    end

    assign busy_o  = (state_q == ST_PEND);
    assign ack_o   = ack_q;
    assign frame_o = frame_q;
    assign seg_o   = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl at DWELL=16: a cycle-indexed display model
// pushes expected outputs into a scoreboard queue, popped one cycle later at the sample point.
module tb_seg_scan_ctrl;

    localparam int DW = 16;
    localparam int FR = 4 * DW;
    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] val;
    logic [3:0]  blank, dp;
    logic [2:0]  bright;
    logic        load;
    logic        busy, ack, frame;
    logic [11:0] seg;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DWELL(DW)) dut (
        .clk_i(clk), .rst_i(rst), .val_i(val), .blank_i(blank), .dp_i(dp),
        .bright_i(bright), .load_i(load), .busy_o(busy), .ack_o(ack),
        .frame_o(frame), .seg_o(seg)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Scoreboard entries: {busy, ack, frame, seg}
    logic [14:0] sb_q [$];
    logic [14:0] exp_o, act_o;

    int          cyc;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_blank, m_dp, p_blank, p_dp;
    logic        m_busy;
    logic [2:0]  m_br;

    task automatic model_reset();
        cyc = 0; m_val = '0; p_val = '0; m_blank = '0; p_blank = '0;
        m_dp = '0; p_dp = '0; m_busy = 1'b0; m_br = 3'd7;
    endtask

    // Predicts outputs after the coming edge from the scan cycle index and current inputs.
    task automatic model_edge();
        int d, cnt;
        logic [3:0] an;
        logic [7:0] h;
        logic [11:0] s;
        logic fr, ak;
        d   = (cyc / DW) % 4;
        cnt = cyc % DW;
        s   = 12'hFFF;
        if ((cnt / (DW / 8)) <= int'(m_br) && !m_blank[d]) begin
            an = 4'hF; an[d] = 1'b0;
            h  = HEX[m_val[d*4 +: 4]];
            s  = {an, ~m_dp[d], h[6:0]};
        end
        fr = (cyc % FR == FR - 1);
        ak = fr && m_busy;
        if (ak) begin
            m_val = p_val; m_blank = p_blank; m_dp = p_dp; m_busy = 1'b0;
        end else if (load && !m_busy) begin
            p_val = val; p_blank = blank; p_dp = dp; m_busy = 1'b1;
        end
        if (cnt == DW - 1) m_br = bright;
        sb_q.push_back({m_busy, ak, fr, s});
        cyc++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        exp_o = sb_q.pop_front();
        act_o = {busy, ack, frame, seg};
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; val = '0; blank = '0; dp = '0; bright = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (seg !== 12'hFFF) $display("FAIL reset_seg got %h want fff", seg); else pass_cnt++;
        chk_cnt++;
        if ({busy, ack, frame} !== 3'b000) $display("FAIL reset_hs got %b want 000", {busy, ack, frame});
        else pass_cnt++;
        rst = 1'b0;
        model_reset();
        tick();
        chk_cnt++;
        if (act_o !== exp_o) $display("FAIL first_cycle_sb got %h want %h", act_o, exp_o); else pass_cnt++;
        chk_cnt++;
        if (seg !== 12'hEC0) $display("FAIL first_digit got %h want ec0", seg); else pass_cnt++;
    endtask

    task automatic test_scan();
        int frames, last_fr, ones;
        frames = 0; last_fr = -1;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            chk_cnt++;
            if (act_o !== exp_o) $display("FAIL scan cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
            ones = $countones(~seg[11:8]);
            chk_cnt++;
            if (ones > 1) $display("FAIL scan_onehot cyc=%0d got %0d anodes want <=1", cyc, ones); else pass_cnt++;
            if (frame) begin
                if (last_fr >= 0) begin
                    chk_cnt++;
                    if (i - last_fr !== FR) $display("FAIL frame_period got %0d want %0d", i - last_fr, FR);
                    else pass_cnt++;
                end
                last_fr = i;
                frames++;
            end
        end
        chk_cnt++;
        if (frames !== 2) $display("FAIL frame_count got %0d want 2", frames); else pass_cnt++;
    endtask

    task automatic test_load();
        bit got;
        logic [11:0] ed [4];
        ed = '{12'hE8E, 12'hDA4, 12'hB08, 12'h7F9};
        val = 16'h1A2F; blank = 4'b0000; dp = 4'b0100; bright = 3'd7; load = 1'b1;
        tick();
        chk_cnt++;
        if (act_o !== exp_o) $display("FAIL load_sb got %h want %h", act_o, exp_o); else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL load_busy got %b want 1", busy); else pass_cnt++;
        load = 1'b0; val = 16'h0000; dp = 4'b1111;
        got = 1'b0;
        for (int i = 0; i < FR + 2 && !got; i++) begin
            tick();
            chk_cnt++;
            if (act_o !== exp_o) $display("FAIL load_wait cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
            if (ack) begin
                got = 1'b1;
                chk_cnt++;
                if (frame !== 1'b1) $display("FAIL ack_frame got %b want 1", frame); else pass_cnt++;
            end
        end
        chk_cnt++;
        if (got !== 1'b1) $display("FAIL load_ack_seen got %b want 1", got); else pass_cnt++;
        for (int i = 0; i < FR; i++) begin
            tick();
            chk_cnt++;
            if (act_o !== exp_o) $display("FAIL load_show cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
            if (i % DW == 0) begin
                chk_cnt++;
                if (seg !== ed[i / DW]) $display("FAIL load_digit%0d got %h want %h", i / DW, seg, ed[i / DW]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int acks, ack_i;
        bit got;
        val = 16'h1234; blank = '0; dp = '0; load = 1'b1;
        tick();
        chk_cnt++;
        if (act_o !== exp_o) $display("FAIL b2b_first got %h want %h", act_o, exp_o); else pass_cnt++;
        val = 16'hFFFF;
        tick();
        chk_cnt++;
        if (act_o !== exp_o) $display("FAIL b2b_second got %h want %h", act_o, exp_o); else pass_cnt++;
        load = 1'b0;
        acks = 0; got = 1'b0;
        for (int i = 0; i < FR + 2 && !got; i++) begin
            tick();
            chk_cnt++;
            if (act_o !== exp_o) $display("FAIL b2b_wait cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
            if (ack) begin acks++; got = 1'b1; end
        end
        tick();
        chk_cnt++;
        if (seg !== 12'hE99) $display("FAIL b2b_ignored got %h want e99", seg); else pass_cnt++;
        for (int i = 0; i < FR + 1 && (cyc % FR) != FR - 1; i++) begin
            tick();
            chk_cnt++;
            if (act_o !== exp_o) $display("FAIL b2b_align cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
            if (ack) acks++;
        end
        val = 16'h5678; load = 1'b1;
        tick();
        load = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL boundary_load_busy got %b want 1", busy); else pass_cnt++;
        ack_i = -1;
        for (int i = 0; i < FR; i++) begin
            tick();
            chk_cnt++;
            if (act_o !== exp_o) $display("FAIL b2b_commit2 cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
            if (ack) begin acks++; ack_i = i; end
        end
        chk_cnt++;
        if (acks !== 2) $display("FAIL b2b_ack_count got %0d want 2", acks); else pass_cnt++;
        chk_cnt++;
        if (ack_i !== FR - 1) $display("FAIL boundary_load_latency got %0d want %0d", ack_i, FR - 1); else pass_cnt++;
    endtask

    task automatic test_bright();
        int lit;
        logic [3:0] anp [4];
        anp = '{4'hE, 4'hD, 4'hB, 4'h7};
        bright = 3'd1;
        tick();
        chk_cnt++;
        if (act_o !== exp_o) $display("FAIL bright_set got %h want %h", act_o, exp_o); else pass_cnt++;
        for (int i = 0; i < FR + 1 && (cyc % FR) != 0; i++) begin
            tick();
            chk_cnt++;
            if (act_o !== exp_o) $display("FAIL bright_align cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
        end
        for (int w = 0; w < 4; w++) begin
            lit = 0;
            for (int j = 0; j < DW; j++) begin
                tick();
                chk_cnt++;
                if (act_o !== exp_o) $display("FAIL bright_sb cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
                if (seg[11:8] != 4'hF) begin
                    lit++;
                    chk_cnt++;
                    if (seg[11:8] !== anp[w]) $display("FAIL bright_anode got %h want %h", seg[11:8], anp[w]);
                    else pass_cnt++;
                end
            end
            chk_cnt++;
            if (lit !== 4) $display("FAIL bright_duty d%0d got %0d want 4", w, lit); else pass_cnt++;
        end
        bright = 3'd7;
    endtask

    task automatic test_blank();
        int lit;
        bit got;
        int want [4];
        want = '{16, 0, 16, 0};
        bright = 3'd7; val = 16'h8888; blank = 4'b1010; dp = '0; load = 1'b1;
        tick();
        load = 1'b0;
        got = 1'b0;
        for (int i = 0; i < FR + 2 && !got; i++) begin
            tick();
            chk_cnt++;
            if (act_o !== exp_o) $display("FAIL blank_wait cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
            if (ack) got = 1'b1;
        end
        chk_cnt++;
        if (got !== 1'b1) $display("FAIL blank_ack_seen got %b want 1", got); else pass_cnt++;
        for (int w = 0; w < 4; w++) begin
            lit = 0;
            for (int j = 0; j < DW; j++) begin
                tick();
                chk_cnt++;
                if (act_o !== exp_o) $display("FAIL blank_sb cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
                if (seg != 12'hFFF) lit++;
            end
            chk_cnt++;
            if (lit !== want[w]) $display("FAIL blank_lit d%0d got %0d want %0d", w, lit, want[w]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        bright = 3'd7; val = 16'hFFFF; blank = '0; dp = 4'hF; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (5) begin
            tick();
            chk_cnt++;
            if (act_o !== exp_o) $display("FAIL rmid_pre cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
        end
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if (seg !== 12'hFFF) $display("FAIL rmid_seg got %h want fff", seg); else pass_cnt++;
        chk_cnt++;
        if ({busy, ack} !== 2'b00) $display("FAIL rmid_busy got %b want 00", {busy, ack}); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        acks = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            chk_cnt++;
            if (act_o !== exp_o) $display("FAIL rmid_post cyc=%0d got %h want %h", cyc, act_o, exp_o); else pass_cnt++;
            if (i == 0) begin
                chk_cnt++;
                if (seg !== 12'hEC0) $display("FAIL rmid_zero got %h want ec0", seg); else pass_cnt++;
            end
            if (ack) acks++;
        end
        chk_cnt++;
        if (acks !== 0) $display("FAIL rmid_no_ack got %0d want 0", acks); else pass_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_bright();
        test_blank();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
